systolic_ctrl: RTL and testbench

Sequencing controller for the 4x4 output-stationary systolic array. It accepts one k-slice per beat over a valid/ready stream: column k of A and row k of B. It skews the slices onto the array's row (A) and column (B) inputs, drives accumulator clear and enable, and drains the pipeline. It then returns the 16 accumulated results row by row over a second valid/ready stream. It sits between the operand buffers and the array in the FFN datapath.

---
 rtl/sa_pkg.sv | 24 ++
 rtl/sa_skew_line.sv | 37 +++
 rtl/systolic_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sa_pkg
//  Description : Shared constants and the controller state type for the 4x4
//                output-stationary systolic array sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sa_pkg;

    localparam int SA_DIM       = 4;
    // Pipeline depth from the last beat to PE(3,3): skew plus array traversal
    localparam int DRAIN_CYCLES = 2*SA_DIM-1;
    localparam int DRAIN_CNT_W  = $clog2(DRAIN_CYCLES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/sa_skew_line.sv
`default_nettype none
// ============================================================================
//  Module      : sa_skew_line
//  Description : DEPTH-stage delay line with asynchronous clear, used to skew
//                one operand lane onto the array edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module sa_skew_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift the lane by one stage per cycle; the last stage drives the array
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/systolic_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_ctrl
//  Description : Job sequencer for the 4x4 output-stationary systolic array:
//                accepts k-slices, skews them onto the array edges, drives
//                accumulator clear/enable, drains, then streams result rows.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_ctrl
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 64,
    parameter int K_MAX      = 256
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start_i,
    input  logic [$clog2(K_MAX+1)-1:0]    k_len_i,
    output logic                          busy_o,
    output logic                          done_o,
    input  logic                          op_vld_i,
    output logic                          op_rdy_o,
    input  logic [4*DATA_WIDTH-1:0]       op_a_i,
    input  logic [4*DATA_WIDTH-1:0]       op_b_i,
    output logic [DATA_WIDTH-1:0]         data_a_0_o,
    output logic [DATA_WIDTH-1:0]         data_a_1_o,
    output logic [DATA_WIDTH-1:0]         data_a_2_o,
    output logic [DATA_WIDTH-1:0]         data_a_3_o,
    output logic [DATA_WIDTH-1:0]         data_b_0_o,
    output logic [DATA_WIDTH-1:0]         data_b_1_o,
    output logic [DATA_WIDTH-1:0]         data_b_2_o,
    output logic [DATA_WIDTH-1:0]         data_b_3_o,
    output logic                          acc_en_o,
    output logic                          acc_clr_o,
    input  logic [16*ACC_WIDTH-1:0]       acc_i,
    output logic                          res_vld_o,
    input  logic                          res_rdy_i,
    output logic [4*ACC_WIDTH-1:0]        res_row_o,
    output logic [1:0]                    res_idx_o
);

    localparam int KW    = $clog2(K_MAX+1);
    localparam int ROW_W = SA_DIM*ACC_WIDTH;

    ctrl_state_t              r_state;
    ctrl_state_t              w_state_nxt;
    logic [KW-1:0]            r_k_len;
    logic [KW-1:0]            r_beat_cnt;
    logic [DRAIN_CNT_W-1:0]   r_drain_cnt;
    logic [1:0]               r_idx;

    logic                     w_beat;
    logic                     w_last_beat;
    logic                     w_drain_end;
    logic                     w_res_acc;
    logic [4*DATA_WIDTH-1:0]  w_a_push;
    logic [4*DATA_WIDTH-1:0]  w_b_push;
    logic [DATA_WIDTH-1:0]    w_a_skew [SA_DIM];
    logic [DATA_WIDTH-1:0]    w_b_skew [SA_DIM];
    logic [ROW_W-1:0]         w_acc_row [SA_DIM];

    assign w_beat      = (r_state == FEED) && op_vld_i;
    assign w_last_beat = w_beat && ((r_beat_cnt + KW'(1)) == r_k_len);
    assign w_drain_end = (r_state == DRAIN) &&
                         (r_drain_cnt == DRAIN_CNT_W'(DRAIN_CYCLES-1));
    assign w_res_acc   = (r_state == OUT) && res_rdy_i;

    // Non-beat cycles inject zeros: a zero operand contributes nothing, so
    // bubbles never disturb the diagonal alignment inside the array.
    assign w_a_push = w_beat ? op_a_i : '0;
    assign w_b_push = w_beat ? op_b_i : '0;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Job length latch, beat/drain counters and result row index
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_k_len     <= '0;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
            r_idx       <= '0;
        end else begin
            if ((r_state == IDLE) && start_i) begin
                r_k_len <= k_len_i;
            end
            if (r_state == CLEAR) begin
                r_beat_cnt <= '0;
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + KW'(1);
            end
            if (r_state == DRAIN) begin
                r_drain_cnt <= r_drain_cnt + DRAIN_CNT_W'(1);
            end else begin
                r_drain_cnt <= '0;
            end
            // Wraps back to 0 on the final row so the next job starts at row 0
            if (w_res_acc) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    // Next-state and control outputs
    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        op_rdy_o    = 1'b0;
        acc_en_o    = 1'b0;
        acc_clr_o   = 1'b0;
        res_vld_o   = 1'b0;
        case (r_state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                acc_clr_o   = 1'b1;
                w_state_nxt = (r_k_len == '0) ? DRAIN : FEED;
            end
            FEED: begin
                op_rdy_o = 1'b1;
                acc_en_o = 1'b1;
                if (w_last_beat) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                acc_en_o = 1'b1;
                if (w_drain_end) begin
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                res_vld_o = 1'b1;
                if (res_rdy_i && (r_idx == 2'd3)) begin
                    done_o      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Lane r of A and lane c of B get r+1 / c+1 register stages
    for (genvar g = 0; g < SA_DIM; g++) begin : g_lane
        sa_skew_line #(
            .WIDTH (DATA_WIDTH),
            .DEPTH (g+1)
        ) u_skew_a (
            .clk    (clk),
            .rstn   (rstn),
            .i_data (w_a_push[g*DATA_WIDTH +: DATA_WIDTH]),
            .o_data (w_a_skew[g])
        );

        sa_skew_line #(
            .WIDTH (DATA_WIDTH),
            .DEPTH (g+1)
        ) u_skew_b (
            .clk    (clk),
            .rstn   (rstn),
            .i_data (w_b_push[g*DATA_WIDTH +: DATA_WIDTH]),
            .o_data (w_b_skew[g])
        );

        assign w_acc_row[g] = acc_i[g*ROW_W +: ROW_W];
    end

    assign data_a_0_o = w_a_skew[0];
    assign data_a_1_o = w_a_skew[1];
    assign data_a_2_o = w_a_skew[2];
    assign data_a_3_o = w_a_skew[3];
    assign data_b_0_o = w_b_skew[0];
    assign data_b_1_o = w_b_skew[1];
    assign data_b_2_o = w_b_skew[2];
    assign data_b_3_o = w_b_skew[3];

    // acc_en_o is low in OUT, so the selected row cannot move during a stall
    assign res_row_o = w_acc_row[r_idx];
    assign res_idx_o = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_ctrl
//  Description : Self-checking bench for systolic_ctrl with a behavioural 4x4
//                array attached and a matrix-product golden model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_ctrl;

    localparam int DW = 16;
    localparam int AW = 64;
    localparam int KM = 256;
    localparam int KW = 9;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start_i = 1'b0;
    logic [KW-1:0]     k_len_i = '0;
    logic              busy_o, done_o;
    logic              op_vld_i = 1'b0;
    logic              op_rdy_o;
    logic [4*DW-1:0]   op_a_i = '0;
    logic [4*DW-1:0]   op_b_i = '0;
    logic [DW-1:0]     data_a_0_o, data_a_1_o, data_a_2_o, data_a_3_o;
    logic [DW-1:0]     data_b_0_o, data_b_1_o, data_b_2_o, data_b_3_o;
    logic              acc_en_o, acc_clr_o;
    logic [16*AW-1:0]  acc_i;
    logic              res_vld_o;
    logic              res_rdy_i = 1'b0;
    logic [4*AW-1:0]   res_row_o;
    logic [1:0]        res_idx_o;

    systolic_ctrl #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(KM)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .k_len_i(k_len_i),
        .busy_o(busy_o), .done_o(done_o),
        .op_vld_i(op_vld_i), .op_rdy_o(op_rdy_o), .op_a_i(op_a_i), .op_b_i(op_b_i),
        .data_a_0_o(data_a_0_o), .data_a_1_o(data_a_1_o),
        .data_a_2_o(data_a_2_o), .data_a_3_o(data_a_3_o),
        .data_b_0_o(data_b_0_o), .data_b_1_o(data_b_1_o),
        .data_b_2_o(data_b_2_o), .data_b_3_o(data_b_3_o),
        .acc_en_o(acc_en_o), .acc_clr_o(acc_clr_o), .acc_i(acc_i),
        .res_vld_o(res_vld_o), .res_rdy_i(res_rdy_i),
        .res_row_o(res_row_o), .res_idx_o(res_idx_o)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- behavioural array attached to the controller --------
    logic signed [DW-1:0] lane_a [4];
    logic signed [DW-1:0] lane_b [4];
    logic signed [DW-1:0] pe_a [4][4];
    logic signed [DW-1:0] pe_b [4][4];
    logic signed [AW-1:0] pe_acc [4][4];

    always_comb begin
        lane_a[0] = data_a_0_o; lane_a[1] = data_a_1_o;
        lane_a[2] = data_a_2_o; lane_a[3] = data_a_3_o;
        lane_b[0] = data_b_0_o; lane_b[1] = data_b_1_o;
        lane_b[2] = data_b_2_o; lane_b[3] = data_b_3_o;
    end

    function automatic logic signed [AW-1:0] mul(logic signed [DW-1:0] a, logic signed [DW-1:0] b);
        longint pa = a;
        longint pb = b;
        return pa * pb;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    pe_a[r][c]   <= '0;
                    pe_b[r][c]   <= '0;
                    pe_acc[r][c] <= '0;
                end
        end else begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    pe_a[r][c] <= (c == 0) ? lane_a[r] : pe_a[r][(c+3)%4];
                    pe_b[r][c] <= (r == 0) ? lane_b[c] : pe_b[(r+3)%4][c];
                    if (acc_clr_o)
                        pe_acc[r][c] <= '0;
                    else if (acc_en_o)
                        pe_acc[r][c] <= pe_acc[r][c] +
                            mul((c == 0) ? lane_a[r] : pe_a[r][(c+3)%4],
                                (r == 0) ? lane_b[c] : pe_b[(r+3)%4][c]);
                end
        end
    end

    always_comb begin
        acc_i = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                acc_i[(4*r+c)*AW +: AW] = pe_acc[r][c];
    end

    // ---------------- bench state --------------------------------------
    int checks = 0;
    int errors = 0;

    logic signed [DW-1:0] mat_a [4][KM];
    logic signed [DW-1:0] mat_b [KM][4];
    logic [AW-1:0]        got [4][4];
    int rows_got, done_cnt, clr_cnt, feed_seen, stall_viol;
    int start_edge, done_cyc, beats_sent, first_beat_edge;
    int hist_a [4][32];
    int hist_b [4][32];

    // Golden C = A*B over the first k slices
    function automatic longint gold(int r, int c, int k);
        longint s = 0;
        for (int kk = 0; kk < k; kk++)
            s += longint'(mat_a[r][kk]) * longint'(mat_b[kk][c]);
        return s;
    endfunction

    function automatic void randomize_mats(int k);
        for (int kk = 0; kk < k; kk++)
            for (int i = 0; i < 4; i++) begin
                mat_a[i][kk] = DW'($urandom);
                mat_b[kk][i] = DW'($urandom);
            end
    endfunction

    // Drive one job; collects results and observations into the globals
    task automatic run_job(input int k, input int vld_pct, input int rdy_pct,
                           input bit hold_start, input int abort_beats);
        bit prev_stall;
        logic [4*AW-1:0] prev_row;
        logic [1:0] prev_idx;
        int b, cyc, o;
        rows_got = 0; done_cnt = 0; clr_cnt = 0; feed_seen = 0; stall_viol = 0;
        done_cyc = -1; first_beat_edge = -1; b = 0; prev_stall = 0;
        prev_row = '0; prev_idx = '0;
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 32; i++) begin
                hist_a[r][i] = 0;
                hist_b[r][i] = 0;
            end
        @(posedge clk); #1;
        start_i = 1'b1; k_len_i = KW'(k); op_vld_i = 1'b0; res_rdy_i = 1'b0;
        @(negedge clk);
        start_edge = edge_cnt + 1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL start_idle busy_o=%b required 0", busy_o);
        end
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk); #1;
            start_i = hold_start;
            if (hold_start) k_len_i = KW'($urandom_range(0, KM));
            if (b < k && $urandom_range(1, 100) <= vld_pct) begin
                op_vld_i = 1'b1;
                op_a_i = {mat_a[3][b], mat_a[2][b], mat_a[1][b], mat_a[0][b]};
                op_b_i = {mat_b[b][3], mat_b[b][2], mat_b[b][1], mat_b[b][0]};
            end else begin
                op_vld_i = 1'b0;
                op_a_i = {$urandom, $urandom};
                op_b_i = {$urandom, $urandom};
            end
            res_rdy_i = ($urandom_range(1, 100) <= rdy_pct);
            @(negedge clk);
            cyc = edge_cnt + 1;
            o = cyc - start_edge;
            if (o >= 0 && o < 32)
                for (int r = 0; r < 4; r++) begin
                    hist_a[r][o] = int'(lane_a[r]);
                    hist_b[r][o] = int'(lane_b[r]);
                end
            if (acc_clr_o) clr_cnt++;
            if (op_rdy_o) feed_seen++;
            if (op_vld_i && op_rdy_o) begin
                if (first_beat_edge < 0) first_beat_edge = edge_cnt + 1;
                b++;
            end
            if (res_vld_o) begin
                if (prev_stall && (res_row_o !== prev_row || res_idx_o !== prev_idx))
                    stall_viol++;
                if (res_rdy_i) begin
                    for (int c = 0; c < 4; c++)
                        got[res_idx_o][c] = res_row_o[c*AW +: AW];
                    rows_got++;
                end
                prev_stall = !res_rdy_i;
                prev_row = res_row_o;
                prev_idx = res_idx_o;
            end else begin
                prev_stall = 0;
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (abort_beats >= 0 && b >= abort_beats) begin
                beats_sent = b;
                return;
            end
            if (done_o) break;
        end
        beats_sent = b;
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL job_timeout done_o not seen, k=%0d beats=%0d", k, b);
        end
    endtask

    // ---------------- tests ----------------------------------------------
    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_o, done_o, op_rdy_o, acc_en_o, acc_clr_o, res_vld_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 000000",
                     {busy_o, done_o, op_rdy_o, acc_en_o, acc_clr_o, res_vld_o});
        end
        checks++;
        if (res_idx_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_idx got %0d required 0", res_idx_o);
        end
        checks++;
        if ({data_a_0_o, data_a_1_o, data_a_2_o, data_a_3_o,
             data_b_0_o, data_b_1_o, data_b_2_o, data_b_3_o} !== '0) begin
            errors++;
            $display("FAIL reset_data lanes not zero");
        end
        rstn = 1'b1;
    endtask

    task automatic test_identity();
        logic [AW-1:0] exp;
        for (int kk = 0; kk < 4; kk++)
            for (int i = 0; i < 4; i++) begin
                mat_a[i][kk] = (i == kk) ? 16'sd1 : 16'sd0;
                mat_b[kk][i] = DW'(kk*4 + i + 1);
            end
        run_job(4, 100, 100, 1'b0, -1);
        for (int r = 0; r < 4; r++) begin
            checks++;
            for (int c = 0; c < 4; c++) begin
                exp = AW'(r*4 + c + 1);
                if (got[r][c] !== exp) begin
                    errors++;
                    $display("FAIL identity_row%0d col%0d got %0d required %0d", r, c, got[r][c], exp);
                    break;
                end
            end
        end
        checks++;
        if (done_cyc !== start_edge + 16) begin
            errors++;
            $display("FAIL identity_done_cycle got %0d required %0d", done_cyc, start_edge + 16);
        end
    endtask

    task automatic test_random_job();
        logic [AW-1:0] exp;
        randomize_mats(37);
        run_job(37, 70, 40, 1'b0, -1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                exp = AW'(gold(r, c, 37));
                checks++;
                if (got[r][c] !== exp) begin
                    errors++;
                    $display("FAIL random_pe%0d%0d got %h required %h", r, c, got[r][c], exp);
                end
            end
        checks++;
        if (stall_viol !== 0) begin
            errors++;
            $display("FAIL random_stall_stable violations %0d required 0", stall_viol);
        end
        checks++;
        if (rows_got !== 4 || done_cnt !== 1) begin
            errors++;
            $display("FAIL random_rows rows=%0d done=%0d required 4/1", rows_got, done_cnt);
        end
    endtask

    task automatic test_k0();
        run_job(0, 100, 100, 1'b0, -1);
        checks++;
        if (feed_seen !== 0) begin
            errors++;
            $display("FAIL k0_feed op_rdy cycles %0d required 0", feed_seen);
        end
        checks++;
        if (clr_cnt !== 1) begin
            errors++;
            $display("FAIL k0_clear acc_clr cycles %0d required 1", clr_cnt);
        end
        for (int r = 0; r < 4; r++) begin
            checks++;
            if ({got[r][0], got[r][1], got[r][2], got[r][3]} !== '0) begin
                errors++;
                $display("FAIL k0_row%0d got nonzero %h required 0", r, got[r][0]);
            end
        end
        checks++;
        if (done_cyc !== start_edge + 12) begin
            errors++;
            $display("FAIL k0_done_cycle got %0d required %0d", done_cyc, start_edge + 12);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] exp;
        int first_done;
        randomize_mats(5);
        run_job(5, 100, 100, 1'b1, -1);
        first_done = done_cyc;
        checks++;
        if (clr_cnt !== 1 || done_cyc !== start_edge + 17) begin
            errors++;
            $display("FAIL b2b_first clr=%0d done=%0d required 1/%0d", clr_cnt, done_cyc, start_edge + 17);
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                exp = AW'(gold(r, c, 5));
                checks++;
                if (got[r][c] !== exp) begin
                    errors++;
                    $display("FAIL b2b_job1_pe%0d%0d got %h required %h", r, c, got[r][c], exp);
                end
            end
        randomize_mats(6);
        run_job(6, 80, 80, 1'b0, -1);
        checks++;
        if (start_edge !== first_done + 1) begin
            errors++;
            $display("FAIL b2b_second_start got %0d required %0d", start_edge, first_done + 1);
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                exp = AW'(gold(r, c, 6));
                checks++;
                if (got[r][c] !== exp) begin
                    errors++;
                    $display("FAIL b2b_job2_pe%0d%0d got %h required %h", r, c, got[r][c], exp);
                end
            end
    endtask

    task automatic test_reset_mid_feed();
        logic [AW-1:0] exp;
        for (int kk = 0; kk < 8; kk++)
            for (int i = 0; i < 4; i++) begin
                mat_a[i][kk] = DW'($urandom_range(1, 30000));
                mat_b[kk][i] = DW'($urandom_range(1, 30000));
            end
        run_job(8, 100, 100, 1'b0, 3);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, op_rdy_o, acc_en_o, acc_clr_o, res_vld_o} !== 6'b0 ||
            res_idx_o !== 2'd0) begin
            errors++;
            $display("FAIL midreset_ctrl got %b idx %0d required 000000 idx 0",
                     {busy_o, done_o, op_rdy_o, acc_en_o, acc_clr_o, res_vld_o}, res_idx_o);
        end
        checks++;
        if ({data_a_0_o, data_a_1_o, data_a_2_o, data_a_3_o,
             data_b_0_o, data_b_1_o, data_b_2_o, data_b_3_o} !== '0) begin
            errors++;
            $display("FAIL midreset_data lanes not zero a0=%h b0=%h", data_a_0_o, data_b_0_o);
        end
        op_vld_i = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        randomize_mats(2);
        run_job(2, 100, 100, 1'b0, -1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                exp = AW'(gold(r, c, 2));
                checks++;
                if (got[r][c] !== exp) begin
                    errors++;
                    $display("FAIL midreset_job_pe%0d%0d got %h required %h", r, c, got[r][c], exp);
                end
            end
    endtask

    task automatic test_skew();
        int t, cyc, exp;
        bit ok;
        logic [AW-1:0] expv;
        for (int i = 0; i < 4; i++) begin
            mat_a[i][0] = DW'(i + 1);
            mat_b[0][i] = DW'(i + 5);
        end
        run_job(1, 100, 100, 1'b0, -1);
        t = first_beat_edge;
        for (int r = 0; r < 4; r++) begin
            ok = 1;
            for (int o = 0; o < 32; o++) begin
                cyc = start_edge + o;
                exp = (cyc == t + 1 + r) ? r + 1 : 0;
                if (hist_a[r][o] != exp) ok = 0;
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL skew_a%0d lane not aligned to cycle %0d", r, t + 1 + r);
            end
            ok = 1;
            for (int o = 0; o < 32; o++) begin
                cyc = start_edge + o;
                exp = (cyc == t + 1 + r) ? r + 5 : 0;
                if (hist_b[r][o] != exp) ok = 0;
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL skew_b%0d lane not aligned to cycle %0d", r, t + 1 + r);
            end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                expv = AW'((r + 1) * (c + 5));
                checks++;
                if (got[r][c] !== expv) begin
                    errors++;
                    $display("FAIL skew_pe%0d%0d got %0d required %0d", r, c, got[r][c], expv);
                end
            end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_random_job();
        test_k0();
        test_back_to_back();
        test_reset_mid_feed();
        test_skew();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
